// File: rtl/imhotep_pkg.sv
// ---------------------------------------------------------------------------
// imhotep_pkg
// Shared types for the execute-stage ALU (alu_mc) and its iterative
// multiply/divide engine (md_iter).
//   op_alu_e    : ALU operation select (RV32I integer ops + RV32M ops)
//   alu_state_e : alu_mc handshake FSM states
//   is_md_op()  : true for any multi-cycle multiply/divide/remainder op
//   is_div_op() : true for the divide/remainder subset
// ---------------------------------------------------------------------------
package imhotep_pkg;

    // Encodings 20..31 are undefined and produce a zero result.
    typedef enum logic [4:0] {
        OP_NOP    = 5'd0,
        OP_ADD    = 5'd1,
        OP_SUB    = 5'd2,
        OP_AND    = 5'd3,
        OP_OR     = 5'd4,
        OP_XOR    = 5'd5,
        OP_SLT    = 5'd6,
        OP_SLTU   = 5'd7,
        OP_SLL    = 5'd8,
        OP_SRL    = 5'd9,
        OP_SRA    = 5'd10,
        OP_JMPR   = 5'd11,
        OP_MUL    = 5'd12,
        OP_MULH   = 5'd13,
        OP_MULHSU = 5'd14,
        OP_MULHU  = 5'd15,
        OP_DIV    = 5'd16,
        OP_DIVU   = 5'd17,
        OP_REM    = 5'd18,
        OP_REMU   = 5'd19
    } op_alu_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_md_op(op_alu_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_div_op(op_alu_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/md_iter.sv
// ---------------------------------------------------------------------------
// md_iter
// Iterative multiply/divide engine for alu_mc.
//   Multiply: shift-add, MUL_BITS_PER_CYCLE multiplier bits per iteration.
//   Divide  : restoring, one quotient bit per iteration.
// Operands are converted to magnitudes on start_i; the sign fix-up is applied
// to the final iteration's value, so result_o is valid in the done_o cycle.
// Divide-by-zero and signed overflow results are fixed at start and
// override the iterative result.
//
// Optional feature macro: IMHOTEP_ALU_EARLY_OUT_EN
//   defined   : early_o flags div-by-zero, signed-overflow DIV/REM and
//               MUL* with a zero operand, so alu_mc can skip iterating.
//   undefined : early_o is tied low; those cases iterate to completion.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   flush_i         abort the op in flight
//   start_i         load operands and begin iterating
//   op_i            MUL*/DIV*/REM* op being started
//   a_i, b_i        operand 1 / operand 2 (raw, as presented at start)
//   early_o         op may complete immediately with early_res_o
//   early_res_o     closed-form result for the early-out cases
//   done_o          final iteration this cycle; result_o is valid
//   result_o        signed-corrected result
// ---------------------------------------------------------------------------
module md_iter
    import imhotep_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  op_alu_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            early_o,
    output logic [XLEN-1:0] early_res_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int K  = MUL_BITS_PER_CYCLE;
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / K - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Control state (reset) and iteration datapath (not reset).
    logic              active_q, active_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;   // mul: {hi, lo}; div: {rem, quo}
    logic [XLEN-1:0]   m_q, m_d;         // multiplicand or divisor magnitude
    op_alu_e           op_q, op_d;
    logic              neg_q, neg_d;     // negate product / quotient
    logic              rneg_q, rneg_d;   // negate remainder
    logic              ovr_q, ovr_d;     // special-case result overrides
    logic [XLEN-1:0]   ovr_res_q, ovr_res_d;

    // ---------------- special cases (combinational on start inputs) -------
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        special     = 1'b0;
        special_res = '0;
        if (is_div_op(op_i)) begin
            if (b_i == '0) begin
                special     = 1'b1;
                special_res = (op_i inside {OP_DIV, OP_DIVU}) ? '1 : a_i;
            end else if ((op_i inside {OP_DIV, OP_REM}) &&
                         (a_i == MOST_NEG) && (b_i == '1)) begin
                special     = 1'b1;
                special_res = (op_i == OP_DIV) ? a_i : '0;
            end
        end else if (is_md_op(op_i) && ((a_i == '0) || (b_i == '0))) begin
            special     = 1'b1;
            special_res = '0;
        end
    end

`ifdef IMHOTEP_ALU_EARLY_OUT_EN
    assign early_o = special;
`else
    assign early_o = 1'b0;
`endif
    assign early_res_o = special_res;

    // ---------------- operand magnitudes ----------------------------------
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg = a_i[XLEN-1] && (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign b_neg = b_i[XLEN-1] && (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // ---------------- one iteration ---------------------------------------
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN+K-1:0] partial;
    logic [2*XLEN-1:0] mul_step, div_step, step;
    logic [XLEN:0]     r_sh, diff;
    logic              last;

    assign hi = prod_q[2*XLEN-1:XLEN];
    assign lo = prod_q[XLEN-1:0];

    // Add m * (low K multiplier bits) into the high half, then shift the
    // whole {hi, lo} right by K; the multiplier drains out of lo as the
    // product fills in from the top.
    assign partial  = {{K{1'b0}}, hi} + ({{K{1'b0}}, m_q} * {{XLEN{1'b0}}, lo[K-1:0]});
    assign mul_step = {partial, lo[XLEN-1:K]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the trial subtraction only when it does not go negative.
    assign r_sh     = {hi, lo[XLEN-1]};
    assign diff     = r_sh - {1'b0, m_q};
    assign div_step = diff[XLEN] ? {r_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};

    assign step   = is_div_op(op_q) ? div_step : mul_step;
    assign last   = (cnt_q == (is_div_op(op_q) ? DIV_LAST : MUL_LAST));
    assign done_o = active_q && last;

    // ---------------- sign fix-up on the final value ----------------------
    logic [2*XLEN-1:0] step_neg;
    logic [XLEN-1:0]   quo, rem;

    assign step_neg = -step;
    assign quo      = step[XLEN-1:0];
    assign rem      = step[2*XLEN-1:XLEN];

    always_comb begin
        result_o = '0;
        case (op_q)
            OP_MUL:                       result_o = neg_q ? step_neg[XLEN-1:0] : step[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = neg_q ? step_neg[2*XLEN-1:XLEN]
                                                           : step[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_o = neg_q ? -quo : quo;
            OP_REM, OP_REMU:              result_o = rneg_q ? -rem : rem;
            default:                      result_o = '0;
        endcase
        if (ovr_q) begin
            result_o = ovr_res_q;
        end
    end

    // ---------------- next state ------------------------------------------
    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        m_d       = m_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        ovr_d     = ovr_q;
        ovr_res_d = ovr_res_q;
        if (start_i) begin
            active_d  = 1'b1;
            cnt_d     = '0;
            op_d      = op_i;
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
            ovr_d     = special;
            ovr_res_d = special_res;
            if (is_div_op(op_i)) begin
                m_d    = b_mag;
                prod_d = {{XLEN{1'b0}}, a_mag};
            end else begin
                m_d    = a_mag;
                prod_d = {{XLEN{1'b0}}, b_mag};
            end
        end else if (active_q) begin
            prod_d = step;
            if (last) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge value of the others; combinational blocks use
    // blocking assignments so later statements see earlier ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: the iteration datapath is deliberately left without reset: it is
    // always loaded by start_i before active_q lets anything read it.
    always_ff @(posedge clk_i) begin
        prod_q    <= prod_d;
        m_q       <= m_d;
        op_q      <= op_d;
        neg_q     <= neg_d;
        rneg_q    <= rneg_d;
        ovr_q     <= ovr_d;
        ovr_res_q <= ovr_res_d;
    end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Integer ops finish in one cycle; MUL*/DIV*/REM* run in md_iter while the
// FSM sits in BUSY and holds off new requests.
//
// Optional feature macro: IMHOTEP_ALU_EARLY_OUT_EN (see md_iter) lets
// div-by-zero, signed-overflow DIV/REM and zero-operand MUL* finish in one
// cycle; results are identical either way.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        abort in-flight op, drop held result and same-cycle request
//   valid_i        op request           ready_o  op accepted when both high
//   op_i           operation select     in1_i / in2_i  operands
//   valid_o        result valid         ready_i  consumer takes result
//   out_o          result (held stable while valid_o && !ready_i)
//   busy_o         iterative op in progress
// ---------------------------------------------------------------------------
module alu_mc
    import imhotep_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  op_alu_e         op_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] out_o,
    output logic            busy_o
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q;
    logic            valid_q;
    logic            busy_q;
    logic [XLEN-1:0] out_q;

    logic            accept;
    logic            go_iter;
    logic            md_start;
    logic            md_early;
    logic [XLEN-1:0] md_early_res;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] quick_res;

    // A held result may be handed over and replaced in the same cycle.
    assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept   = valid_i && ready_o;
    assign go_iter  = is_md_op(op_i) && !md_early;
    assign md_start = accept && go_iter && !flush_i;

    // ---------------- single-cycle datapath -------------------------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sum;

    assign shamt = in2_i[SHW-1:0];
    assign sum   = in1_i + in2_i;

    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = in1_i - in2_i;
            OP_AND:  alu_res = in1_i & in2_i;
            OP_OR:   alu_res = in1_i | in2_i;
            OP_XOR:  alu_res = in1_i ^ in2_i;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in1_i) < $signed(in2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in1_i < in2_i)};
            OP_SLL:  alu_res = in1_i << shamt;
            OP_SRL:  alu_res = in1_i >> shamt;
            OP_SRA:  alu_res = $signed(in1_i) >>> shamt;
            OP_JMPR: alu_res = {sum[XLEN-1:1], 1'b0};
            default: alu_res = '0;
        endcase
    end

    assign quick_res = md_early ? md_early_res : alu_res;

    md_iter #(
        .XLEN               (XLEN),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_md_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .start_i     (md_start),
        .op_i        (op_i),
        .a_i         (in1_i),
        .b_i         (in2_i),
        .early_o     (md_early),
        .early_res_o (md_early_res),
        .done_o      (md_done),
        .result_o    (md_result)
    );

    // ---------------- handshake FSM ---------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= '0;
        end else if (flush_i) begin
            // out_q is kept; valid_q low already hides it.
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (go_iter) begin
                            state_q <= BUSY;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            out_q   <= quick_res;
                        end
                    end else if ((state_q == DONE) && ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        out_q   <= md_result;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign out_o   = out_q;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc (XLEN=32, MUL_BITS_PER_CYCLE=1).
// Expected results and latencies come from a plain-arithmetic reference
// model; directed cases follow with randomized ops and backpressure.
// Build with +define+IMHOTEP_ALU_EARLY_OUT_EN to match an early-out DUT.
// ---------------------------------------------------------------------------
module tb_alu_mc;
    import imhotep_pkg::*;

    localparam int XLEN = 32;
    localparam int MBPC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    op_alu_e     op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_mc #(
        .XLEN               (XLEN),
        .MUL_BITS_PER_CYCLE (MBPC)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .op_i    (op),
        .in1_i   (in1),
        .in2_i   (in2),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .out_o   (out),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model -------------------------------------
    function automatic logic [31:0] ref_result(op_alu_e o, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:    return a << b[4:0];
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    begin p = sa >>> b[4:0]; return p[31:0]; end
            OP_JMPR:   begin p = ua + ub; return p[31:0] & 32'hFFFF_FFFE; end
            OP_MUL:    begin p = ua * ub; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf)        return a;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'd0) return a;
                if (ovf)        return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            OP_REMU:   return (b == 32'd0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    // Cycles from the acceptance edge until valid_o is seen.
    function automatic int ref_latency(op_alu_e o, logic [31:0] a, logic [31:0] b);
        if (!is_md_op(o)) return 1;
`ifdef IMHOTEP_ALU_EARLY_OUT_EN
        if ((o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) && (a == 0 || b == 0)) return 1;
        if ((o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && b == 0) return 1;
        if ((o inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        if (o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return XLEN / MBPC + 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- one transaction -------------------------------------
    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic do_op(input op_alu_e o, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input string tag, output logic [31:0] got);
        int          cyc;
        int          exp_lat;
        logic [31:0] exp_res;
        logic [31:0] held;
        exp_res = ref_result(o, a, b);
        exp_lat = ref_latency(o, a, b);
        check({tag, "/ready_idle"}, ready_out, 1);
        op       = o;
        in1      = a;
        in2      = b;
        valid_in = 1'b1;
        ready_in = (stall == 0);
        @(posedge clk); #1;
        // Scramble inputs: the op must have been captured at acceptance.
        valid_in = 1'b0;
        op       = op_alu_e'($urandom_range(0, 31));
        in1      = $urandom;
        in2      = $urandom;
        cyc      = 1;
        if (exp_lat > 1) begin
            check({tag, "/busy"}, busy, 1);
            check({tag, "/ready_busy"}, ready_out, 0);
        end
        while (!valid_out && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "/latency"}, cyc, exp_lat);
        check({tag, "/result"}, out, exp_res);
        got  = out;
        held = out;
        for (int i = 0; i < stall; i++) begin
            valid_in = 1'b1;    // must not be accepted while stalled
            op       = OP_ADD;
            in1      = $urandom;
            check({tag, "/ready_stall"}, ready_out, 0);
            @(posedge clk); #1;
            check({tag, "/valid_hold"}, valid_out, 1);
            check({tag, "/out_hold"}, out, held);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        check({tag, "/released"}, valid_out, 0);
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        logic [31:0] r;
        int          seen;
        rst      = 1'b1;
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        op       = OP_NOP;
        in1      = '0;
        in2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/valid_o", valid_out, 0);
        check("reset/out_o", out, 0);
        check("reset/busy_o", busy, 0);
        check("reset/ready_o", ready_out, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: ADD then SUB accepted in the DONE cycle.
        op = OP_ADD; in1 = 5; in2 = 7; valid_in = 1'b1; ready_in = 1'b1;
        @(posedge clk); #1;
        check("b2b/add_valid", valid_out, 1);
        check("b2b/add_out", out, 12);
        check("b2b/ready_done", ready_out, 1);
        op = OP_SUB; in1 = 3; in2 = 5;
        @(posedge clk); #1;
        check("b2b/sub_valid", valid_out, 1);
        check("b2b/sub_out", out, 32'hFFFF_FFFE);
        valid_in = 1'b0;
        @(posedge clk); #1;
        check("b2b/idle", valid_out, 0);

        // Directed multiply / divide values.
        do_op(OP_MUL,   32'hFFFF_FFFF, 32'd2,          0, "mul",     r); check("mul/const", r, 32'hFFFF_FFFE);
        do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0, "mulhu",   r); check("mulhu/const", r, 32'hFFFF_FFFE);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,          0, "div",     r); check("div/const", r, 32'hFFFF_FFFD);
        do_op(OP_REM,   32'hFFFF_FFF9, 32'd2,          0, "rem",     r); check("rem/const", r, 32'hFFFF_FFFF);
        do_op(OP_DIV,   32'd10,        32'd0,          0, "div0",    r); check("div0/const", r, 32'hFFFF_FFFF);
        do_op(OP_REM,   32'd10,        32'd0,          0, "rem0",    r); check("rem0/const", r, 32'd10);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  0, "divovf",  r); check("divovf/const", r, 32'h8000_0000);
        do_op(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF,  0, "removf",  r); check("removf/const", r, 32'd0);
        do_op(OP_MULH,  32'd0,         32'h1234_5678,  0, "mulzero", r); check("mulzero/const", r, 32'd0);
        do_op(OP_SRA,   32'h8000_0000, 32'h0000_0104,  0, "sra",     r); check("sra/const", r, 32'hF800_0000);
        do_op(OP_JMPR,  32'h0000_1001, 32'h0000_0002,  0, "jmpr",    r); check("jmpr/const", r, 32'h0000_1002);
        do_op(op_alu_e'(5'd25), 32'hAAAA_5555, 32'd3,  0, "undef",   r); check("undef/const", r, 32'd0);

        // Backpressure: result held for 5 cycles, then one transfer.
        do_op(OP_MULHSU, 32'hFFFF_FFFE, 32'h8000_0001, 5, "hold", r);

        // Flush mid-divide; a request in the flush cycle is dropped.
        op = OP_DIVU; in1 = 100; in2 = 7; valid_in = 1'b1; ready_in = 1'b1;
        @(posedge clk); #1;                 // cycle T+1
        valid_in = 1'b0;
        repeat (9) begin @(posedge clk); #1; end   // cycle T+10
        check("flush/busy_before", busy, 1);
        flush = 1'b1;
        op = OP_ADD; in1 = 4; in2 = 4; valid_in = 1'b1;
        @(posedge clk); #1;                 // cycle T+11
        flush    = 1'b0;
        valid_in = 1'b0;
        check("flush/ready", ready_out, 1);
        check("flush/valid", valid_out, 0);
        check("flush/busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        check("flush/no_result", seen, 0);
        do_op(OP_ADD, 32'd1, 32'd1, 0, "post_flush", r); check("post_flush/const", r, 32'd2);

        // Reset mid-op clears out_o as well.
        op = OP_DIV; in1 = 1000; in2 = 3; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid/out", out, 0);
        check("rst_mid/valid", valid_out, 0);
        check("rst_mid/busy", busy, 0);
        check("rst_mid/ready", ready_out, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        check("rst_mid/no_result", seen, 0);

        // Randomized ops with occasional backpressure.
        for (int i = 0; i < 150; i++) begin
            op_alu_e     ro;
            logic [31:0] ra;
            logic [31:0] rb;
            int          st;
            ro = op_alu_e'($urandom_range(0, 31));
            ra = pick_operand();
            rb = pick_operand();
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(ro, ra, rb, st, $sformatf("rand%0d_op%0d", i, ro), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
